// File: rtl/rlbp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rlbp_pkg : state codes and phase-to-switch decode for rlbp_readout_seq
// Revision : 1.0
// ----------------------------------------------------------------------------
package rlbp_pkg;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_RST  = 3'd1;
  localparam logic [2:0] c_ST_SMP  = 3'd2;
  localparam logic [2:0] c_ST_CONV = 3'd3;
  localparam logic [2:0] c_ST_OUT  = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;

  typedef struct packed {
    logic sh_rst;
    logic sh;
    logic sh_cmp;
    logic sw1;
    logic sw2;
  } sw_t;

  // Each analog phase owns its switches exclusively; all other states open everything.
  function automatic sw_t phase_sw(input logic [2:0] state);
    sw_t sw;
    sw = '0;
    case (state)
      c_ST_RST:  begin sw.sh_rst = 1'b1; sw.sw1 = 1'b1; end
      c_ST_SMP:  sw.sh = 1'b1;
      c_ST_CONV: begin sw.sh_cmp = 1'b1; sw.sw2 = 1'b1; end
      default:   sw = '0;
    endcase
    return sw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rlbp_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rlbp_sync : multi-flop synchroniser with rising-edge detect for the comparator
// Revision  : 1.0
// ----------------------------------------------------------------------------
module rlbp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cmp,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_cmp};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/rlbp_readout_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rlbp_readout_seq : N-pixel reset/sample/single-slope sequencer with streamed results
// Revision         : 1.0
// ----------------------------------------------------------------------------
module rlbp_readout_seq
  import rlbp_pkg::*;
#(
  parameter int N_PIX       = 12,
  parameter int CNT_W       = 10,
  parameter int PH_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                    wb_clk_i,
  input  logic                                    wb_rst_i,
  input  logic                                    start_i,
  input  logic                                    abort_i,
  input  logic [PH_W-1:0]                         t_rst_i,
  input  logic [PH_W-1:0]                         t_sh_i,
  input  logic [CNT_W-1:0]                        cnt_max_i,
  input  logic                                    cmp_i,
  output logic [N_PIX-1:0]                        pd_sel_o,
  output logic                                    sh_rst_o,
  output logic                                    sh_o,
  output logic                                    sh_cmp_o,
  output logic                                    sw1_o,
  output logic                                    sw2_o,
  output logic                                    counter_rst_o,
  output logic [CNT_W-1:0]                        data_o,
  output logic [$clog2(N_PIX > 1 ? N_PIX : 2)-1:0] pix_idx_o,
  output logic                                    sat_o,
  output logic                                    data_valid_o,
  input  logic                                    data_ready_i,
  output logic                                    busy_o,
  output logic                                    done_o
);

  localparam int                 c_IDX_W = $clog2(N_PIX > 1 ? N_PIX : 2);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N_PIX - 1);

  logic [2:0]         r_state;
  logic [c_IDX_W-1:0] r_pix;
  logic [PH_W-1:0]    r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic [PH_W-1:0]    r_t_rst;
  logic [PH_W-1:0]    r_t_sh;
  logic [CNT_W-1:0]   r_cnt_max;
  logic [CNT_W-1:0]   r_data;
  logic               r_sat;
  sw_t                r_sw;
  logic [N_PIX-1:0]   r_pd_sel;
  logic               r_cnt_rst;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic [2:0]         w_state_nxt;
  logic [c_IDX_W-1:0] w_pix_nxt;
  logic               w_rise;
  logic               w_conv_end;
  logic               w_accept;
  logic [PH_W-1:0]    w_rst_load_in;
  logic [PH_W-1:0]    w_rst_load;
  logic [PH_W-1:0]    w_sh_load;

  rlbp_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .i_cmp  (cmp_i),
    .o_rise (w_rise)
  );

  // Phase counter is loaded with length-1; a zero length still yields one cycle.
  assign w_rst_load_in = (t_rst_i == '0) ? '0 : t_rst_i - PH_W'(1);
  assign w_rst_load    = (r_t_rst == '0) ? '0 : r_t_rst - PH_W'(1);
  assign w_sh_load     = (r_t_sh  == '0) ? '0 : r_t_sh  - PH_W'(1);
  assign w_conv_end    = w_rise || (r_cnt == r_cnt_max);
  assign w_accept      = (r_state == c_ST_OUT) && data_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix;
    case (r_state)
      c_ST_IDLE: if (start_i) begin
        w_state_nxt = c_ST_RST;
        w_pix_nxt   = '0;
      end
      c_ST_RST:  if (r_phase == '0) w_state_nxt = c_ST_SMP;
      c_ST_SMP:  if (r_phase == '0) w_state_nxt = c_ST_CONV;
      c_ST_CONV: if (w_conv_end) w_state_nxt = c_ST_OUT;
      c_ST_OUT:  if (w_accept) begin
        if (r_pix == c_LAST) begin
          w_state_nxt = c_ST_DONE;
        end else begin
          w_state_nxt = c_ST_RST;
          w_pix_nxt   = r_pix + c_IDX_W'(1);
        end
      end
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || abort_i) begin
      r_state   <= c_ST_IDLE;
      r_pix     <= '0;
      r_phase   <= '0;
      r_cnt     <= '0;
      r_t_rst   <= '0;
      r_t_sh    <= '0;
      r_cnt_max <= '0;
      r_data    <= '0;
      r_sat     <= 1'b0;
      r_sw      <= '0;
      r_pd_sel  <= '0;
      r_cnt_rst <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pix   <= w_pix_nxt;
      case (r_state)
        c_ST_IDLE: if (start_i) begin
          r_t_rst   <= t_rst_i;
          r_t_sh    <= t_sh_i;
          r_cnt_max <= cnt_max_i;
          r_phase   <= w_rst_load_in;
        end
        c_ST_RST:  r_phase <= (r_phase == '0) ? w_sh_load : r_phase - PH_W'(1);
        c_ST_SMP:  begin
          if (r_phase != '0) r_phase <= r_phase - PH_W'(1);
          r_cnt <= '0;
        end
        // An edge coinciding with timeout reports the live count, which equals cnt_max.
        c_ST_CONV: if (w_conv_end) begin
          r_data <= w_rise ? r_cnt : r_cnt_max;
          r_sat  <= ~w_rise;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        c_ST_OUT:  if (w_accept) r_phase <= w_rst_load;
        default:   begin end
      endcase

      // Outputs are registered from the next state so they line up with r_state.
      r_sw      <= phase_sw(w_state_nxt);
      r_pd_sel  <= (w_state_nxt inside {c_ST_RST, c_ST_SMP, c_ST_CONV, c_ST_OUT})
                   ? (N_PIX'(1) << w_pix_nxt) : '0;
      r_cnt_rst <= (w_state_nxt == c_ST_CONV) && (r_state != c_ST_CONV);
      r_valid   <= (w_state_nxt == c_ST_OUT);
      r_busy    <= (w_state_nxt != c_ST_IDLE);
      r_done    <= (w_state_nxt == c_ST_DONE);
    end
  end

  assign pd_sel_o      = r_pd_sel;
  assign sh_rst_o      = r_sw.sh_rst;
  assign sh_o          = r_sw.sh;
  assign sh_cmp_o      = r_sw.sh_cmp;
  assign sw1_o         = r_sw.sw1;
  assign sw2_o         = r_sw.sw2;
  assign counter_rst_o = r_cnt_rst;
  assign data_o        = r_data;
  assign pix_idx_o     = r_pix;
  assign sat_o         = r_sat;
  assign data_valid_o  = r_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rlbp_readout_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rlbp_readout_seq : scenario bench for rlbp_readout_seq (12-pixel and 1-pixel builds)
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tb_rlbp_readout_seq;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int d_tab[12];

  // 12-pixel instance
  logic        rst, start, abort_s, cmp, ready;
  logic [7:0]  t_rst, t_sh;
  logic [9:0]  cmax;
  logic [11:0] pd_sel;
  logic        sh_rst, sh, sh_cmp, sw1, sw2, cnt_rst, sat, valid, busy, done;
  logic [9:0]  data;
  logic [3:0]  pix_idx;
  logic [35:0] outs1;
  assign outs1 = {pd_sel, sh_rst, sh, sh_cmp, sw1, sw2, cnt_rst, data, pix_idx, sat, valid, busy, done};

  rlbp_readout_seq #(.N_PIX(12), .CNT_W(10), .PH_W(8), .SYNC_STAGES(S)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort_s),
    .t_rst_i(t_rst), .t_sh_i(t_sh), .cnt_max_i(cmax), .cmp_i(cmp),
    .pd_sel_o(pd_sel), .sh_rst_o(sh_rst), .sh_o(sh), .sh_cmp_o(sh_cmp),
    .sw1_o(sw1), .sw2_o(sw2), .counter_rst_o(cnt_rst), .data_o(data),
    .pix_idx_o(pix_idx), .sat_o(sat), .data_valid_o(valid), .data_ready_i(ready),
    .busy_o(busy), .done_o(done)
  );

  // 1-pixel, 4-bit instance
  logic        s_start, s_abort, s_cmp, s_ready;
  logic [7:0]  s_t_rst, s_t_sh;
  logic [3:0]  s_cmax;
  logic [0:0]  s_pd_sel;
  logic        s_sh_rst, s_sh, s_sh_cmp, s_sw1, s_sw2, s_cnt_rst, s_sat, s_valid, s_busy, s_done;
  logic [3:0]  s_data;
  logic [0:0]  s_pix_idx;
  logic [15:0] outs2;
  assign outs2 = {s_pd_sel, s_sh_rst, s_sh, s_sh_cmp, s_sw1, s_sw2, s_cnt_rst, s_data, s_pix_idx,
                  s_sat, s_valid, s_busy, s_done};

  rlbp_readout_seq #(.N_PIX(1), .CNT_W(4), .PH_W(8), .SYNC_STAGES(S)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(s_start), .abort_i(s_abort),
    .t_rst_i(s_t_rst), .t_sh_i(s_t_sh), .cnt_max_i(s_cmax), .cmp_i(s_cmp),
    .pd_sel_o(s_pd_sel), .sh_rst_o(s_sh_rst), .sh_o(s_sh), .sh_cmp_o(s_sh_cmp),
    .sw1_o(s_sw1), .sw2_o(s_sw2), .counter_rst_o(s_cnt_rst), .data_o(s_data),
    .pix_idx_o(s_pix_idx), .sat_o(s_sat), .data_valid_o(s_valid), .data_ready_i(s_ready),
    .busy_o(s_busy), .done_o(s_done)
  );

  // mode 0: cmp rises d_tab[pix] cycles after CONV entry; 1: cmp held low; 2: cmp held high.
  task automatic run_frame(input int trst, input int tsh, input int cmax_v, input int mode,
                           input int bp, input bit noise, input string tag);
    int pix, cyc, rst_len, sh_len, conv_t, wait_c, dones, bad, unstable, exp_d, exp_rst, exp_sh;
    bit exp_s;
    logic [9:0]  hold_d;
    logic [3:0]  hold_i;
    logic        hold_s;
    logic [11:0] one;
    one = 12'd1;
    pix = 0; cyc = 0; rst_len = 0; sh_len = 0; conv_t = -1; wait_c = 0; bad = 0; unstable = 0;
    hold_d = '0; hold_i = '0; hold_s = 1'b0;
    exp_rst = (trst == 0) ? 1 : trst;
    exp_sh  = (tsh == 0) ? 1 : tsh;
    ready = 1'b0;
    cmp = (mode == 2);
    repeat (4) @(negedge clk);
    t_rst = trst[7:0]; t_sh = tsh[7:0]; cmax = cmax_v[9:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (pix < 12 && cyc < 8000) begin
      cyc++;
      if (noise) begin
        start = 1'($urandom); t_rst = 8'($urandom); t_sh = 8'($urandom); cmax = 10'($urandom);
      end
      if ($countones({sh_rst, sh, sh_cmp}) > 1 || sw1 !== sh_rst || sw2 !== sh_cmp ||
          busy !== 1'b1 || done !== 1'b0) bad++;
      if (sh_rst) rst_len++;
      if (sh) sh_len++;
      if (cnt_rst) conv_t = 0; else if (conv_t >= 0) conv_t++;
      if (mode == 0 && conv_t == d_tab[pix]) cmp = 1'b1;
      if (valid) begin
        if (wait_c == 0) begin
          hold_d = data; hold_i = pix_idx; hold_s = sat;
        end else if (data !== hold_d || pix_idx !== hold_i || sat !== hold_s || sh_rst !== 1'b0) begin
          unstable++;
        end
        if (wait_c >= bp) begin
          ready = 1'b1;
          if (mode == 0) begin
            exp_d = d_tab[pix] + S;
            exp_s = (exp_d > cmax_v);
            if (exp_s) exp_d = cmax_v;
          end else begin
            exp_d = cmax_v;
            exp_s = 1'b1;
          end
          n_chk++;
          if (pix_idx !== pix[3:0]) begin
            n_fail++; $display("FAIL %s pix_idx: got %0d expected %0d", tag, pix_idx, pix);
          end
          n_chk++;
          if (data !== exp_d[9:0] || sat !== exp_s) begin
            n_fail++;
            $display("FAIL %s result pix %0d: got data %0d sat %0d expected data %0d sat %0d",
                     tag, pix, data, sat, exp_d, exp_s);
          end
          n_chk++;
          if (rst_len != exp_rst || sh_len != exp_sh) begin
            n_fail++;
            $display("FAIL %s phase lengths pix %0d: got rst %0d sh %0d expected rst %0d sh %0d",
                     tag, pix, rst_len, sh_len, exp_rst, exp_sh);
          end
          n_chk++;
          if (pd_sel !== (one << pix)) begin
            n_fail++; $display("FAIL %s pd_sel pix %0d: got %b expected %b", tag, pix, pd_sel, one << pix);
          end
          pix++; rst_len = 0; sh_len = 0; conv_t = -1; wait_c = 0;
          cmp = (mode == 2);
          if (pix == 12) start = 1'b0;
        end else begin
          ready = 1'b0;
          wait_c++;
        end
      end else begin
        ready = 1'b0;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    if (noise) begin start = 1'b0; t_rst = 8'd0; t_sh = 8'd0; cmax = 10'd0; end
    n_chk++;
    if (pix != 12) begin
      n_fail++; $display("FAIL %s frame timeout: got %0d results expected 12", tag, pix);
    end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_chk++;
    if (dones != 1) begin
      n_fail++; $display("FAIL %s done pulses: got %0d expected 1", tag, dones);
    end
    n_chk++;
    if (busy !== 1'b0 || pd_sel !== 12'd0) begin
      n_fail++; $display("FAIL %s idle after frame: got busy %0d pd_sel %0d expected 0 0", tag, busy, pd_sel);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s switch/busy/done cycles: got %0d bad cycles expected 0", tag, bad);
    end
    n_chk++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL %s held result stability: got %0d unstable cycles expected 0", tag, unstable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (outs1 !== 36'd0 || outs2 !== 16'd0) begin
      n_fail++; $display("FAIL reset outputs: got %h/%h expected 0/0", outs1, outs2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs1 !== 36'd0 || outs2 !== 16'd0) begin
      n_fail++; $display("FAIL idle outputs: got %h/%h expected 0/0", outs1, outs2);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 12; i++) d_tab[i] = 40;
    run_frame(3, 2, 500, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_saturation();
    run_frame(0, 0, 100, 1, 0, 1'b0, "sat");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 12; i++) d_tab[i] = int'($urandom_range(0, 30));
    run_frame(2, 1, 300, 0, 10, 1'b0, "backpressure");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 12; i++) d_tab[i] = int'($urandom_range(0, 50));
      run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                (f == 0) ? 0 : int'($urandom_range(1, 60)), 0, int'($urandom_range(0, 3)),
                1'b0, "random");
    end
  endtask

  task automatic test_abort();
    int convs, dones, cyc;
    logic [11:0] one;
    one = 12'd1;
    convs = 0; dones = 0; cyc = 0;
    cmp = 1'b0; ready = 1'b1;
    t_rst = 8'd2; t_sh = 8'd2; cmax = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (convs < 6 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cnt_rst) convs++;
    end
    n_chk++;
    if (convs != 6 || pd_sel !== (one << 5)) begin
      n_fail++; $display("FAIL abort reach pixel 5 CONV: got convs %0d pd_sel %b expected 6 %b", convs, pd_sel, one << 5);
    end
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    n_chk++;
    if (outs1 !== 36'd0) begin
      n_fail++; $display("FAIL abort outputs: got %h expected 0", outs1);
    end
    for (int k = 0; k < 30; k++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    n_chk++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort quiet: got %0d done/busy cycles expected 0", dones);
    end
    ready = 1'b0;
    for (int i = 0; i < 12; i++) d_tab[i] = 7;
    run_frame(1, 1, 200, 0, 0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_out();
    int cyc;
    cyc = 0;
    cmp = 1'b0; ready = 1'b0;
    t_rst = 8'd1; t_sh = 8'd1; cmax = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || data !== 10'd5 || sat !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_out pending result: got valid %0d data %0d sat %0d expected 1 5 1", valid, data, sat);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (outs1 !== 36'd0) begin
      n_fail++; $display("FAIL reset_mid_out outputs: got %h expected 0", outs1);
    end
  endtask

  task automatic test_busy_noise_cmp_high();
    run_frame(4, 3, 20, 2, 1, 1'b1, "noise_cmp_high");
  endtask

  task automatic test_single_pixel(input int d, input int exp_d, input bit exp_s);
    int conv_t, cyc;
    bit got;
    conv_t = -1; cyc = 0; got = 1'b0;
    s_cmp = 1'b0; s_ready = 1'b1; s_cmax = 4'd15; s_t_rst = 8'd1; s_t_sh = 8'd1;
    repeat (4) @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!got && cyc < 200) begin
      cyc++;
      if (s_cnt_rst) conv_t = 0; else if (conv_t >= 0) conv_t++;
      if (conv_t == d) s_cmp = 1'b1;
      if (s_valid) begin
        got = 1'b1;
        n_chk++;
        if (s_data !== exp_d[3:0] || s_sat !== exp_s || s_pix_idx !== 1'b0 || s_pd_sel !== 1'b1) begin
          n_fail++;
          $display("FAIL single d=%0d: got data %0d sat %0d idx %0d sel %0d expected data %0d sat %0d idx 0 sel 1",
                   d, s_data, s_sat, s_pix_idx, s_pd_sel, exp_d, exp_s);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (!got || s_done !== 1'b1) begin
      n_fail++; $display("FAIL single done after one result: got result %0d done %0d expected 1 1", got, s_done);
    end
    @(negedge clk);
    n_chk++;
    if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL single idle: got done %0d busy %0d expected 0 0", s_done, s_busy);
    end
    s_cmp = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; abort_s = 1'b0; cmp = 1'b0; ready = 1'b0;
    t_rst = 8'd0; t_sh = 8'd0; cmax = 10'd0;
    s_start = 1'b0; s_abort = 1'b0; s_cmp = 1'b0; s_ready = 1'b0;
    s_t_rst = 8'd0; s_t_sh = 8'd0; s_cmax = 4'd0;
    test_reset();
    test_basic_frame();
    test_saturation();
    test_backpressure();
    test_random_frames();
    test_abort();
    test_reset_mid_out();
    test_busy_noise_cmp_high();
    test_single_pixel(15 - S, 15, 1'b0);
    test_single_pixel(16 - S, 15, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
